// File: rtl/inst_fetch_buffer_pkg.sv
// rtl/inst_fetch_buffer_pkg.sv - shared widths, entry type and accept encodings for the fetch buffer
package inst_fetch_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int BATCH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Decode may only take an in-order prefix of the two presented slots.
  typedef enum logic [1:0] {
    ACC_NONE  = 2'b00,
    ACC_SLOT0 = 2'b01,
    ACC_BOTH  = 2'b11
  } dec_accept_e;

  function automatic logic is_legal_accept(input logic [BATCH-1:0] acc);
    return (acc == ACC_NONE) || (acc == ACC_SLOT0) || (acc == ACC_BOTH);
  endfunction

  function automatic logic [1:0] popcount2(input logic [BATCH-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// rtl/inst_fetch_buffer_if.sv - fetch-side and decode-side batch interfaces
interface fetch_batch_if;
  import inst_fetch_buffer_pkg::*;

  logic [ADDR_W-1:0] inst_addr_0;
  logic [ADDR_W-1:0] inst_addr_1;
  logic [INST_W-1:0] inst_0;
  logic [INST_W-1:0] inst_1;
  logic [BATCH-1:0]  inst_valid;
  logic              ready;

  modport master (output inst_addr_0, inst_addr_1, inst_0, inst_1, inst_valid, input ready);
  modport slave  (input inst_addr_0, inst_addr_1, inst_0, inst_1, inst_valid, output ready);
endinterface

interface dispatch_batch_if;
  import inst_fetch_buffer_pkg::*;

  logic [ADDR_W-1:0] inst_addr_0;
  logic [ADDR_W-1:0] inst_addr_1;
  logic [INST_W-1:0] inst_0;
  logic [INST_W-1:0] inst_1;
  logic [BATCH-1:0]  inst_valid;
  logic [BATCH-1:0]  accept;

  modport master (output inst_addr_0, inst_addr_1, inst_0, inst_1, inst_valid, input accept);
  modport slave  (input inst_addr_0, inst_addr_1, inst_0, inst_1, inst_valid, output accept);
endinterface

// File: rtl/inst_fetch_buffer_ptr_ctrl.sv
// rtl/inst_fetch_buffer_ptr_ctrl.sv - pointer, occupancy, write-select and overflow control
module ibuf_ptr_ctrl
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [BATCH-1:0]           in_valid,
  input  logic [BATCH-1:0]           dec_accept,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       in_ready,
  output logic [BATCH-1:0]           out_valid,
  output logic                       overflow,
  output logic                       wr_en_0,
  output logic                       wr_sel_0,
  output logic                       wr_en_1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             enq_fire;
  logic             enq_bad;
  logic             acc_bad;
  logic [BATCH-1:0] deq_mask;
  logic [1:0]       enq_n;
  logic [1:0]       deq_n;

  // Handshake decode; in_ready looks only at registered count so decode never feeds fetch.
  always_comb begin
    in_ready  = (count <= CW'(DEPTH - 2));
    out_valid = {count >= CW'(2), count != '0};
    enq_fire  = in_ready && (in_valid != '0);
    enq_bad   = !in_ready && (in_valid != '0);
    acc_bad   = !is_legal_accept(dec_accept);
    deq_mask  = acc_bad ? '0 : (dec_accept & out_valid);
    enq_n     = enq_fire ? popcount2(in_valid) : 2'd0;
    deq_n     = popcount2(deq_mask);
    // A lone slot-1 entry is compacted down into the wr_ptr position.
    wr_en_0   = enq_fire;
    wr_sel_0  = (in_valid == 2'b10);
    wr_en_1   = enq_fire && (in_valid == 2'b11);
  end

  // Pointer/count update with flush dominating any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_n);
      rd_ptr <= rd_ptr + PW'(deq_n);
      count  <= count + CW'(enq_n) - CW'(deq_n);
      if (enq_bad || acc_bad) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - 2-wide instruction fetch buffer top; IBUF_PERF_EN adds stall/empty counters
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_batch_if.slave             fetch,
  dispatch_batch_if.master         dispatch,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   out_count
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_empty_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             in_ready;
  logic [BATCH-1:0] out_valid;
  logic             wr_en_0;
  logic             wr_sel_0;
  logic             wr_en_1;
  fetch_entry_t     slot_0;
  fetch_entry_t     slot_1;
  fetch_entry_t     head_0;
  fetch_entry_t     head_1;
  fetch_entry_t     mem [DEPTH];

  ibuf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (fetch.inst_valid),
    .dec_accept (dispatch.accept),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .overflow   (out_overflow),
    .wr_en_0    (wr_en_0),
    .wr_sel_0   (wr_sel_0),
    .wr_en_1    (wr_en_1)
  );

  // Pack incoming slots into entries.
  always_comb begin
    slot_0.addr = fetch.inst_addr_0;
    slot_0.inst = fetch.inst_0;
    slot_1.addr = fetch.inst_addr_1;
    slot_1.inst = fetch.inst_1;
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr_en_0) mem[wr_ptr] <= wr_sel_0 ? slot_1 : slot_0;
      if (wr_en_1) mem[wr_ptr + PW'(1)] <= slot_1;
    end
  end

  // Head muxing; slots beyond the current occupancy read as zero.
  always_comb begin
    head_0               = out_valid[0] ? mem[rd_ptr] : '0;
    head_1               = out_valid[1] ? mem[rd_ptr + PW'(1)] : '0;
    dispatch.inst_addr_0 = head_0.addr;
    dispatch.inst_0      = head_0.inst;
    dispatch.inst_addr_1 = head_1.addr;
    dispatch.inst_1      = head_1.inst;
    dispatch.inst_valid  = out_valid;
    fetch.ready          = in_ready;
    out_count            = count;
  end

`ifdef IBUF_PERF_EN
  // Performance counters survive flush so they measure whole-run behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (!in_ready && (fetch.inst_valid != '0) && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (count == '0)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - scoreboard bench for inst_fetch_buffer; covers IBUF_PERF_EN when defined
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] IKEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        out_overflow;
  logic [3:0]  out_count;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_empty_cycles;
  logic [31:0] exp_stall;
  logic [31:0] exp_empty;
`endif

  fetch_batch_if    fb ();
  dispatch_batch_if db ();

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fetch        (fb),
    .dispatch     (db),
    .out_overflow (out_overflow),
    .out_count    (out_count)
`ifdef IBUF_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] q[$];
  logic        exp_ovf;
  logic [31:0] pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    logic [63:0] e0, e1;
    sz = q.size();
    e0 = (sz >= 1) ? q[0] : 64'd0;
    e1 = (sz >= 2) ? q[1] : 64'd0;
    check({tag, ".count"},   64'(out_count), 64'(sz));
    check({tag, ".valid"},   64'(db.inst_valid), {62'd0, sz >= 2, sz >= 1});
    check({tag, ".ready"},   64'(fb.ready), 64'((DEPTH - sz) >= 2));
    check({tag, ".ovf"},     64'(out_overflow), 64'(exp_ovf));
    check({tag, ".slot0"},   {db.inst_addr_0, db.inst_0}, e0);
    check({tag, ".slot1"},   {db.inst_addr_1, db.inst_1}, e1);
`ifdef IBUF_PERF_EN
    check({tag, ".pstall"},  64'(perf_stall_cycles), 64'(exp_stall));
    check({tag, ".pempty"},  64'(perf_empty_cycles), 64'(exp_empty));
`endif
  endtask

  task automatic step(input string tag, input logic [1:0] m, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [1:0] acc, input logic fl);
    int   sz, ndeq;
    logic rdy;
    fb.inst_addr_0 = a0;
    fb.inst_0      = a0 ^ IKEY;
    fb.inst_addr_1 = a1;
    fb.inst_1      = a1 ^ IKEY;
    fb.inst_valid  = m;
    db.accept      = acc;
    flush          = fl;
    sz  = q.size();
    rdy = (DEPTH - sz) >= 2;
`ifdef IBUF_PERF_EN
    if (!rdy && m != 2'b00 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    if (sz == 0) exp_empty++;
`endif
    if (fl) begin
      q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (acc == 2'b10) begin
        exp_ovf = 1'b1;
        ndeq = 0;
      end else begin
        ndeq = ((acc[0] && sz >= 1) ? 1 : 0) + ((acc[1] && sz >= 2) ? 1 : 0);
      end
      repeat (ndeq) void'(q.pop_front());
      if (m != 2'b00) begin
        if (rdy) begin
          if (m[0]) q.push_back({a0, a0 ^ IKEY});
          if (m[1]) q.push_back({a1, a1 ^ IKEY});
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    fb.inst_valid = 2'b00;
    db.accept     = 2'b00;
    flush         = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fb.inst_addr_0 = '0; fb.inst_addr_1 = '0; fb.inst_0 = '0; fb.inst_1 = '0;
    fb.inst_valid = 2'b00;
    db.accept = 2'b00;
    exp_ovf = 1'b0;
`ifdef IBUF_PERF_EN
    exp_stall = '0;
    exp_empty = '0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset");

    step("b11", 2'b11, 32'h1000, 32'h1004, 2'b00, 1'b0);
    check("b11.addr0", 64'(db.inst_addr_0), 64'h1000);
    check("b11.addr1", 64'(db.inst_addr_1), 64'h1004);
    step("drain1", 2'b00, 0, 0, 2'b11, 1'b0);

    step("b10", 2'b10, 32'h9999, 32'h2004, 2'b00, 1'b0);
    check("b10.addr0", 64'(db.inst_addr_0), 64'h2004);
    step("drain2", 2'b00, 0, 0, 2'b01, 1'b0);

    for (int i = 0; i < 4; i++)
      step("fill", 2'b11, 32'h3000 + 32'(16 * i), 32'h3008 + 32'(16 * i), 2'b00, 1'b0);
    check("full.ready", 64'(fb.ready), 64'd0);
    step("over", 2'b11, 32'h4000, 32'h4004, 2'b00, 1'b0);
    check("over.count", 64'(out_count), 64'd8);
    check("over.ovf", 64'(out_overflow), 64'd1);

    step("fl0", 2'b00, 0, 0, 2'b00, 1'b1);
    pc = 32'h5000;
    for (int i = 0; i < 2; i++) begin
      step("pre", 2'b11, pc, pc + 4, 2'b00, 1'b0);
      pc += 8;
    end
    for (int i = 0; i < 8; i++) begin
      step("steady", 2'b11, pc, pc + 4, 2'b11, 1'b0);
      pc += 8;
    end
    check("steady.count", 64'(out_count), 64'd4);

    step("fl1", 2'b00, 0, 0, 2'b00, 1'b1);
    step("two", 2'b11, 32'h6000, 32'h6004, 2'b00, 1'b0);
    step("acc10", 2'b00, 0, 0, 2'b10, 1'b0);
    check("acc10.ovf", 64'(out_overflow), 64'd1);
    check("acc10.count", 64'(out_count), 64'd2);
    step("to4", 2'b11, 32'h6008, 32'h600C, 2'b00, 1'b0);
    step("to5", 2'b01, 32'h6010, 32'h6014, 2'b00, 1'b0);
    step("flenq", 2'b11, 32'h7000, 32'h7004, 2'b01, 1'b1);
    check("flenq.count", 64'(out_count), 64'd0);
    check("flenq.ovf", 64'(out_overflow), 64'd0);

    for (int i = 0; i < 4; i++)
      step("pfill", 2'b11, 32'h8000 + 32'(16 * i), 32'h8008 + 32'(16 * i), 2'b00, 1'b0);
    step("pstall", 2'b11, 32'h8800, 32'h8804, 2'b00, 1'b0);
    step("fl2", 2'b00, 0, 0, 2'b00, 1'b1);

    pc = 32'hA000;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] m, acc;
      int r;
      m = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      acc = (r < 8) ? 2'b11 : (r < 13) ? 2'b01 : (r < 19) ? 2'b00 : 2'b10;
      step("rand", m, pc, pc + 4, acc, ($urandom_range(0, 24) == 0));
      pc += 8;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
